// File: rtl/online_mult_sequencer.sv
// Cycle-level sequencer for an MSD-first online multiplier datapath.
// Takes one signed-digit operand pair per step and waits DELTA steps before the first product digit.
// Emits one product digit per step, then drains DELTA steps with zero inputs and pulses done.
module online_mult_sequencer #(
  parameter int unsigned N_DIGITS = 64,
  parameter int unsigned DELTA    = 3,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned CNT_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              digit_valid,
  output logic              digit_ready,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  step_idx,
  output logic              ca_we,
  output logic [ADDR_W-1:0] ca_waddr,
  output logic              enable_adder,
  output logic              enable_shift,
  output logic              zero_in,
  output logic              clear_dp,
  output logic              p_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_INIT  = 2'b01,
    S_RUN   = 2'b10,
    S_DRAIN = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] LAST_INIT  = CNT_W'(DELTA - 1);
  localparam logic [CNT_W-1:0] LAST_RUN   = CNT_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(N_DIGITS + DELTA - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  state_t             state_r;
  state_t             state_n;
  logic [CNT_W-1:0]   idx_r;
  logic [CNT_W-1:0]   idx_n;
  logic               done_n;
  logic               kill;

  // State, step counter and done pulse; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      idx_r   <= '0;
      done    <= 1'b0;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
      done    <= done_n;
    end
  end

  // Next-state, step advance and combinational datapath strobes
  always_comb begin
    state_n      = state_r;
    idx_n        = idx_r;
    done_n       = 1'b0;
    digit_ready  = 1'b0;
    ca_we        = 1'b0;
    ca_waddr     = '0;
    enable_adder = 1'b0;
    enable_shift = 1'b0;
    zero_in      = 1'b0;
    clear_dp     = 1'b0;
    p_valid      = 1'b0;
    // A mid-operation reset cancels exactly like abort: no strobes this cycle
    kill         = abort | rst;

    unique case (state_r)
      S_IDLE: begin
        if (start && !kill) begin
          clear_dp = 1'b1;
          state_n  = S_INIT;
          idx_n    = '0;
        end
      end

      S_INIT: begin
        ca_waddr = ADDR_W'(idx_r);
        if (kill) begin
          state_n = S_IDLE;
          idx_n   = '0;
        end else begin
          digit_ready = 1'b1;
          if (digit_valid) begin
            ca_we        = 1'b1;
            enable_adder = 1'b1;
            idx_n        = idx_r + ONE;
            if (idx_r == LAST_INIT) state_n = S_RUN;
          end
        end
      end

      S_RUN: begin
        ca_waddr = ADDR_W'(idx_r);
        if (kill) begin
          state_n = S_IDLE;
          idx_n   = '0;
        end else begin
          digit_ready = 1'b1;
          if (digit_valid) begin
            ca_we        = 1'b1;
            enable_adder = 1'b1;
            enable_shift = 1'b1;
            p_valid      = 1'b1;
            idx_n        = idx_r + ONE;
            if (idx_r == LAST_RUN) state_n = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (kill) begin
          state_n = S_IDLE;
          idx_n   = '0;
        end else begin
          zero_in      = 1'b1;
          enable_adder = 1'b1;
          enable_shift = 1'b1;
          p_valid      = 1'b1;
          if (idx_r == LAST_DRAIN) begin
            state_n = S_IDLE;
            idx_n   = '0;
            done_n  = 1'b1;
          end else begin
            idx_n = idx_r + ONE;
          end
        end
      end
    endcase
  end

  assign state    = state_r;
  assign step_idx = idx_r;
  assign busy     = (state_r != S_IDLE);

endmodule

// File: tb/tb_online_mult_sequencer.sv
// Self-checking bench for online_mult_sequencer (N_DIGITS=8, DELTA=3) against a step-count reference model.
module tb_online_mult_sequencer;

  localparam int unsigned N  = 8;
  localparam int unsigned D  = 3;
  localparam int unsigned AW = 7;
  localparam int unsigned CW = 9;
  localparam int unsigned VW = 2 + CW + 1 + AW + 8;

  localparam int B_DR   = 0;
  localparam int B_DONE = 1;
  localparam int B_BUSY = 2;
  localparam int B_PV   = 3;
  localparam int B_CD   = 4;
  localparam int B_EA   = 7;
  localparam int B_WE   = 15;
  localparam int B_IDX  = 16;
  localparam int B_ST   = 25;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic          digit_valid;
  logic          digit_ready;
  logic [1:0]    state;
  logic [CW-1:0] step_idx;
  logic          ca_we;
  logic [AW-1:0] ca_waddr;
  logic          enable_adder;
  logic          enable_shift;
  logic          zero_in;
  logic          clear_dp;
  logic          p_valid;
  logic          busy;
  logic          done;

  int tests_run;
  int tests_failed;

  // Reference model: an operation is just "active" plus a step count j
  bit          m_active;
  int unsigned m_j;
  bit          m_done;

  online_mult_sequencer #(
    .N_DIGITS(N), .DELTA(D), .ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .digit_valid(digit_valid),
    .digit_ready(digit_ready), .state(state), .step_idx(step_idx), .ca_we(ca_we),
    .ca_waddr(ca_waddr), .enable_adder(enable_adder), .enable_shift(enable_shift),
    .zero_in(zero_in), .clear_dp(clear_dp), .p_valid(p_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] pack(input logic [1:0] s, input logic [CW-1:0] idx,
      input logic we, input logic [AW-1:0] wa, input logic ea, input logic es, input logic zi,
      input logic cd, input logic pv, input logic bz, input logic dn, input logic dr);
    return {s, idx, we, wa, ea, es, zi, cd, pv, bz, dn, dr};
  endfunction

  // Expected outputs this cycle, from the step count and the rules for each phase
  function automatic logic [VW-1:0] model_exp(input logic st, input logic ab, input logic dv);
    logic       in_ops, drain, consume, moving, prod;
    logic [1:0] code;
    in_ops  = m_active && (m_j < N);
    drain   = m_active && (m_j >= N);
    consume = in_ops && dv && !ab;
    moving  = consume || (drain && !ab);
    prod    = moving && (m_j >= D);
    if (!m_active)   code = 2'b00;
    else if (m_j < D) code = 2'b01;
    else if (m_j < N) code = 2'b10;
    else             code = 2'b11;
    return pack(code, CW'(m_j), consume, in_ops ? AW'(m_j) : AW'(0), moving, prod,
                drain && !ab, !m_active && st && !ab, prod, m_active, m_done, in_ops && !ab);
  endfunction

  task automatic model_step(input logic st, input logic ab, input logic dv, input logic r);
    logic moving;
    moving = m_active && !ab && ((m_j >= N) || dv);
    if (r) begin
      m_active = 0; m_j = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (st && !ab) begin m_active = 1; m_j = 0; end
      end else if (ab) begin
        m_active = 0; m_j = 0;
      end else if (moving) begin
        if (m_j == N + D - 1) begin m_active = 0; m_j = 0; m_done = 1; end
        else m_j = m_j + 1;
      end
    end
  endtask

  // Drive one cycle, sample on the falling edge, advance the model, return at posedge+1
  task automatic cyc(input logic st, input logic ab, input logic dv, input logic r,
                     output logic [VW-1:0] obs, output logic [VW-1:0] ex, output logic [VW-1:0] msk);
    start = st; abort = ab; digit_valid = dv; rst = r;
    @(negedge clk);
    obs = pack(state, step_idx, ca_we, ca_waddr, enable_adder, enable_shift, zero_in,
               clear_dp, p_valid, busy, done, digit_ready);
    ex  = model_exp(st, ab, dv);
    msk = '1;
    if (r) msk = pack(2'b11, '1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    else if (ab) msk[B_DR] = 1'b0;
    model_step(st, ab, dv, r);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] o, e, m;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, o, e, m);
    for (int c = 0; c < 4; c++) begin
      cyc(1'b0, 1'b0, 1'b1, logic'(c < 1), o, e, m);
      tests_run++;
      if ((o & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL reset c%0d got %h expected %h", c, o & m, e & m);
      end
    end
    tests_run++;
    if (o !== '0) begin
      tests_failed++;
      $display("FAIL reset_idle_outputs got %h expected 0", o);
    end
  endtask

  task automatic test_nominal();
    logic [VW-1:0] o, e, m;
    int pv, done_at, we_init;
    pv = 0; done_at = -1; we_init = 0;
    for (int c = 0; c < 16; c++) begin
      cyc(logic'(c == 0), 1'b0, 1'b1, 1'b0, o, e, m);
      tests_run++;
      if ((o & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL nominal c%0d got %h expected %h", c, o & m, e & m);
      end
      if (o[B_PV]) pv++;
      if (o[B_DONE] && done_at < 0) done_at = c;
      if (c >= 1 && c <= 3 && o[B_WE] && !o[B_PV]) we_init++;
      if (c == 0) begin
        tests_run++;
        if (o[B_CD] !== 1'b1) begin
          tests_failed++;
          $display("FAIL nominal_clear_dp got %b expected 1", o[B_CD]);
        end
      end
    end
    tests_run++;
    if (pv != 8) begin tests_failed++; $display("FAIL nominal_pvalid_count got %0d expected 8", pv); end
    tests_run++;
    if (done_at != 12) begin tests_failed++; $display("FAIL nominal_done_cycle got %0d expected 12", done_at); end
    tests_run++;
    if (we_init != 3) begin tests_failed++; $display("FAIL nominal_init_writes got %0d expected 3", we_init); end
  endtask

  task automatic test_stall();
    logic [VW-1:0] o, e, m;
    int pv, done_at;
    pv = 0; done_at = -1;
    for (int c = 0; c < 20; c++) begin
      cyc(logic'(c == 0), 1'b0, logic'(!(c >= 6 && c <= 9)), 1'b0, o, e, m);
      tests_run++;
      if ((o & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL stall c%0d got %h expected %h", c, o & m, e & m);
      end
      if (o[B_PV]) pv++;
      if (o[B_DONE] && done_at < 0) done_at = c;
      if (c >= 6 && c <= 9) begin
        tests_run++;
        if (o[B_IDX +: CW] !== CW'(5) || o[B_WE] || o[B_EA] || o[B_PV]) begin
          tests_failed++;
          $display("FAIL stall_hold c%0d got idx=%0d we=%b ea=%b pv=%b expected idx=5 and strobes 0",
                   c, o[B_IDX +: CW], o[B_WE], o[B_EA], o[B_PV]);
        end
      end
    end
    tests_run++;
    if (pv != 8) begin tests_failed++; $display("FAIL stall_pvalid_count got %0d expected 8", pv); end
    tests_run++;
    if (done_at != 16) begin tests_failed++; $display("FAIL stall_done_cycle got %0d expected 16", done_at); end
  endtask

  task automatic test_abort();
    logic [VW-1:0] o, e, m;
    int pv, done_at, early_done;
    pv = 0; done_at = -1; early_done = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(logic'(c == 0), logic'(c == 5), 1'b1, 1'b0, o, e, m);
      tests_run++;
      if ((o & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL abort c%0d got %h expected %h", c, o & m, e & m);
      end
      if (o[B_DONE]) early_done++;
      if (c == 6) begin
        tests_run++;
        if (o[B_ST +: 2] !== 2'b00 || o[B_IDX +: CW] !== '0 || o[B_BUSY] !== 1'b0) begin
          tests_failed++;
          $display("FAIL abort_idle got state=%b idx=%0d busy=%b expected 00/0/0",
                   o[B_ST +: 2], o[B_IDX +: CW], o[B_BUSY]);
        end
      end
    end
    tests_run++;
    if (early_done != 0) begin tests_failed++; $display("FAIL abort_no_done got %0d expected 0", early_done); end
    for (int c = 0; c < 14; c++) begin
      cyc(logic'(c == 0), 1'b0, 1'b1, 1'b0, o, e, m);
      tests_run++;
      if ((o & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL abort_rerun c%0d got %h expected %h", c, o & m, e & m);
      end
      if (o[B_PV]) pv++;
      if (o[B_DONE] && done_at < 0) done_at = c;
    end
    tests_run++;
    if (pv != 8 || done_at != 12) begin
      tests_failed++;
      $display("FAIL abort_rerun_result got pv=%0d done@%0d expected pv=8 done@12", pv, done_at);
    end
  endtask

  task automatic test_rst_drain();
    logic [VW-1:0] o, e, m;
    int dones;
    dones = 0;
    for (int c = 0; c < 18; c++) begin
      cyc(logic'(c == 0), 1'b0, 1'b1, logic'(c == 10 || c == 11), o, e, m);
      tests_run++;
      if ((o & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL rst_drain c%0d got %h expected %h", c, o & m, e & m);
      end
      if (c == 10) begin
        tests_run++;
        if (o[B_ST +: 2] !== 2'b11 || o[B_IDX +: CW] !== CW'(9)) begin
          tests_failed++;
          $display("FAIL rst_drain_entry got state=%b idx=%0d expected 11/9", o[B_ST +: 2], o[B_IDX +: CW]);
        end
      end
      if (c >= 10 && o[B_DONE]) dones++;
      if (c == 12) begin
        tests_run++;
        if (o !== '0) begin
          tests_failed++;
          $display("FAIL rst_drain_idle got %h expected 0", o);
        end
      end
    end
    tests_run++;
    if (dones != 0) begin tests_failed++; $display("FAIL rst_drain_no_done got %0d expected 0", dones); end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] o, e, m;
    int pv2, done2;
    pv2 = 0; done2 = -1;
    for (int c = 0; c < 26; c++) begin
      cyc(logic'(c == 0 || c == 12), 1'b0, 1'b1, 1'b0, o, e, m);
      tests_run++;
      if ((o & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL b2b c%0d got %h expected %h", c, o & m, e & m);
      end
      if (c == 12) begin
        tests_run++;
        if (o[B_DONE] !== 1'b1 || o[B_CD] !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_restart got done=%b clear_dp=%b expected 1/1", o[B_DONE], o[B_CD]);
        end
      end
      if (c == 13) begin
        tests_run++;
        if (o[B_ST +: 2] !== 2'b01) begin
          tests_failed++;
          $display("FAIL b2b_init got state=%b expected 01", o[B_ST +: 2]);
        end
      end
      if (c > 12 && o[B_PV]) pv2++;
      if (c > 12 && o[B_DONE] && done2 < 0) done2 = c;
    end
    tests_run++;
    if (pv2 != 8 || done2 != 24) begin
      tests_failed++;
      $display("FAIL b2b_second got pv=%0d done@%0d expected pv=8 done@24", pv2, done2);
    end
  endtask

  task automatic test_ignore_start();
    logic [VW-1:0] o, e, m;
    int pv, done_at;
    pv = 0; done_at = -1;
    for (int c = 0; c < 14; c++) begin
      cyc(logic'(c == 0 || c == 3), 1'b0, 1'b1, 1'b0, o, e, m);
      tests_run++;
      if ((o & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL ignore_start c%0d got %h expected %h", c, o & m, e & m);
      end
      if (o[B_PV]) pv++;
      if (o[B_DONE] && done_at < 0) done_at = c;
    end
    tests_run++;
    if (pv != 8 || done_at != 12) begin
      tests_failed++;
      $display("FAIL ignore_start_run got pv=%0d done@%0d expected pv=8 done@12", pv, done_at);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0, o, e, m);
    tests_run++;
    if (o[B_CD] !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_abort_clear got %b expected 0", o[B_CD]);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, o, e, m);
    tests_run++;
    if (o[B_ST +: 2] !== 2'b00 || o[B_BUSY] !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_abort_state got state=%b busy=%b expected 00/0", o[B_ST +: 2], o[B_BUSY]);
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] o, e, m;
    logic st, ab, dv, r;
    for (int c = 0; c < 400; c++) begin
      st = logic'($urandom_range(3) == 0);
      ab = logic'($urandom_range(24) == 0);
      dv = logic'($urandom_range(3) != 0);
      r  = logic'($urandom_range(59) == 0);
      cyc(st, ab, dv, r, o, e, m);
      tests_run++;
      if ((o & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL random c%0d in st=%b ab=%b dv=%b rst=%b got %h expected %h",
                 c, st, ab, dv, r, o & m, e & m);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    m_active = 0; m_j = 0; m_done = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; digit_valid = 1'b0;
    test_reset();
    test_nominal();
    test_stall();
    test_abort();
    test_rst_drain();
    test_back_to_back();
    test_ignore_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
